// File: rtl/tiny_alu_pkg.sv
// -----------------------------------------------------------------------------
// tiny_alu_pkg
// Shared definitions for the tiny ALU command issuer:
//   - ALU opcode encodings (NOP_OP..MUL_OP)
//   - OPCODE_LAST, the highest legal opcode, used for the legality check
//   - issuer FSM state encoding
//   - opcode_illegal(), a helper that applies the legality check
// -----------------------------------------------------------------------------
package tiny_alu_pkg;

    localparam int NOP_OP      = 0;
    localparam int ADD_OP      = 1;
    localparam int AND_OP      = 2;
    localparam int XOR_OP      = 3;
    localparam int MUL_OP      = 4;
    localparam int OPCODE_LAST = MUL_OP;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } issuer_state_e;

    // Opcodes are unsigned, so widening to int before comparing is safe.
    function automatic logic opcode_illegal(input int unsigned op);
        return op > OPCODE_LAST;
    endfunction

endpackage

// File: rtl/tiny_alu_cmd_fifo.sv
// -----------------------------------------------------------------------------
// tiny_alu_cmd_fifo
// Synchronous FIFO with wrap-around read/write pointers and a level counter.
// DEPTH must be a power of two (the pointers wrap by overflowing).
// Ports:
//   clk_i, reset_n_i   clock, synchronous active-low reset
//   push_i, wdata_i    write request and data (ignored when full)
//   pop_i              read request (ignored when empty)
//   rdata_o            head entry, valid whenever empty_o is low
//   full_o, empty_o    occupancy flags
//   level_o            current number of entries
// -----------------------------------------------------------------------------
module tiny_alu_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/tiny_alu_issuer.sv
// -----------------------------------------------------------------------------
// tiny_alu_issuer
// Command front-end for the 8-bit tiny ALU. Commands {a, b, opcode} arrive on
// a valid/ready stream and are buffered in a FIFO; one at a time they are
// issued to the ALU with a single-cycle start pulse, and the result is
// returned on a valid/ready response stream with an error flag.
//
// Optional feature: define TINY_ALU_ISSUER_TIMEOUT_EN to bound the time spent
// waiting for alu_done_i (TIMEOUT_CYCLES); expiry returns err=1, result=0.
//
// Ports:
//   clk_i, reset_n_i                 clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o          command handshake
//   cmd_a_i, cmd_b_i, cmd_opcode_i   command payload
//   rsp_valid_o/rsp_ready_i          response handshake
//   rsp_result_o, rsp_opcode_o,
//   rsp_err_o                        response payload
//   alu_a_o, alu_b_o, alu_opcode_o,
//   alu_start_o                      to the ALU
//   alu_result_i, alu_done_i         from the ALU
//   fifo_level_o                     command FIFO occupancy
// -----------------------------------------------------------------------------
module tiny_alu_issuer
    import tiny_alu_pkg::*;
#(
    parameter int DATA_BITS      = 8,
    parameter int OPCODE_BITS    = 3,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic [DATA_BITS-1:0]          cmd_a_i,
    input  logic [DATA_BITS-1:0]          cmd_b_i,
    input  logic [OPCODE_BITS-1:0]        cmd_opcode_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [2*DATA_BITS-1:0]        rsp_result_o,
    output logic [OPCODE_BITS-1:0]        rsp_opcode_o,
    output logic                          rsp_err_o,
    output logic [DATA_BITS-1:0]          alu_a_o,
    output logic [DATA_BITS-1:0]          alu_b_o,
    output logic [OPCODE_BITS-1:0]        alu_opcode_o,
    output logic                          alu_start_o,
    input  logic [2*DATA_BITS-1:0]        alu_result_i,
    input  logic                          alu_done_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int CMD_W = 2*DATA_BITS + OPCODE_BITS;

    issuer_state_e state_q, state_d;

    logic                   fifo_full, fifo_empty;
    logic [CMD_W-1:0]       head;
    logic [DATA_BITS-1:0]   head_a, head_b;
    logic [OPCODE_BITS-1:0] head_op;
    logic                   head_illegal;
    logic                   pop;
    logic                   timeout;

    logic [DATA_BITS-1:0]   op_a_q, op_b_q;
    logic [OPCODE_BITS-1:0] op_code_q;
    logic [2*DATA_BITS-1:0] rsp_result_q;
    logic [OPCODE_BITS-1:0] rsp_opcode_q;
    logic                   rsp_err_q;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    assign cmd_ready_o = ~fifo_full;

    tiny_alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (cmd_valid_i),
        .wdata_i   ({cmd_a_i, cmd_b_i, cmd_opcode_i}),
        .pop_i     (pop),
        .rdata_o   (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level_o)
    );

    assign {head_a, head_b, head_op} = head;
    assign head_illegal = opcode_illegal(32'(head_op));
    assign pop          = (state_q == ST_IDLE) & ~fifo_empty;

    // ------------------------------------------------------------------
    // Optional WAIT timeout
    // ------------------------------------------------------------------
`ifdef TINY_ALU_ISSUER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q;

    // Held at zero outside WAIT, so it is already clear on entry.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i || state_q != ST_WAIT) wait_cnt_q <= '0;
        else                                  wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end

    assign timeout = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = head_illegal ? ST_RESP : ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (alu_done_i || timeout) state_d = ST_RESP;
            ST_RESP:  if (rsp_ready_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        alu_start_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            ST_ISSUE: alu_start_o = 1'b1;
            ST_RESP:  rsp_valid_o = 1'b1;
            default:  ;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_code_q    <= '0;
            rsp_result_q <= '0;
            rsp_opcode_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            if (pop) begin
                op_a_q    <= head_a;
                op_b_q    <= head_b;
                op_code_q <= head_op;
                // Illegal opcodes skip the ALU entirely.
                if (head_illegal) begin
                    rsp_result_q <= '0;
                    rsp_opcode_q <= head_op;
                    rsp_err_q    <= 1'b1;
                end
            end
            // done takes priority over a same-cycle timeout.
            if (state_q == ST_WAIT) begin
                if (alu_done_i) begin
                    rsp_result_q <= alu_result_i;
                    rsp_opcode_q <= op_code_q;
                    rsp_err_q    <= 1'b0;
                end else if (timeout) begin
                    rsp_result_q <= '0;
                    rsp_opcode_q <= op_code_q;
                    rsp_err_q    <= 1'b1;
                end
            end
        end
    end

    assign alu_a_o      = op_a_q;
    assign alu_b_o      = op_b_q;
    assign alu_opcode_o = op_code_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_opcode_o = rsp_opcode_q;
    assign rsp_err_o    = rsp_err_q;

endmodule

// File: tb/tb_tiny_alu_issuer.sv
module tb_tiny_alu_issuer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a, cmd_b;
    logic [2:0]  cmd_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_opcode;
    logic        rsp_err;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_op;
    logic        alu_start;
    logic [15:0] alu_result;
    logic        alu_done;
    logic [2:0]  level;

    int n_vec  = 0;
    int n_fail = 0;
    int start_cnt = 0;
    logic alu_suppress;

    tiny_alu_issuer dut (
        .clk_i        (clk),
        .reset_n_i    (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_a_i      (cmd_a),
        .cmd_b_i      (cmd_b),
        .cmd_opcode_i (cmd_op),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .rsp_opcode_o (rsp_opcode),
        .rsp_err_o    (rsp_err),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_opcode_o (alu_op),
        .alu_start_o  (alu_start),
        .alu_result_i (alu_result),
        .alu_done_i   (alu_done),
        .fifo_level_o (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural tiny ALU: registers result and done one edge after start.
    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
        case (op)
            3'd1:    return 16'(a) + 16'(b);
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a ^ b};
            3'd4:    return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            alu_done   <= 1'b0;
            alu_result <= '0;
        end else begin
            alu_done <= alu_start & ~alu_suppress;
            if (alu_start) alu_result <= alu_f(alu_a, alu_b, alu_op);
        end
    end

    always @(posedge clk) if (alu_start) start_cnt <= start_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one command; returns #1 after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic acc;
        int   n;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        n = 0;
        do begin
            acc = cmd_ready;
            step();
            n++;
        end while (!acc && n < 100);
        cmd_valid = 1'b0;
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    // Accept one response and compare its payload.
    task automatic get_rsp(input string tag, input logic [15:0] res,
                           input logic [2:0] op, input logic err);
        int n;
        rsp_ready = 1'b1;
        n = 0;
        while (!rsp_valid && n < 60) begin
            step();
            n++;
        end
        if (!rsp_valid) begin
            chk({tag, "_no_rsp"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_result"}, 32'(rsp_result), 32'(res));
            chk({tag, "_opcode"}, 32'(rsp_opcode), 32'(op));
            chk({tag, "_err"},    32'(rsp_err),    32'(err));
            step();
        end
        rsp_ready = 1'b0;
    endtask

    initial begin
        int s0;
        logic seen;
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; alu_suppress = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_op = '0;

        // Reset state
        step(); step();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_start", 32'(alu_start), 32'd0);
        chk("rst_level",     32'(level),     32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_result",    32'(rsp_result), 32'd0);
        chk("rst_alu_a",     32'(alu_a),     32'd0);
        rst_n = 1'b1;
        step();

        // ADD 200+100 with exact cycle timing
        send(8'd200, 8'd100, 3'd1);                       // edge 0
        chk("add_lvl_e0",   32'(level),     32'd1);
        chk("add_start_e0", 32'(alu_start), 32'd0);
        step();                                          // edge 1
        chk("add_start_e1", 32'(alu_start), 32'd1);
        chk("add_lvl_e1",   32'(level),     32'd0);
        chk("add_alu_a",    32'(alu_a),     32'd200);
        chk("add_alu_b",    32'(alu_b),     32'd100);
        step();                                          // edge 2
        chk("add_start_e2", 32'(alu_start), 32'd0);
        chk("add_vld_e2",   32'(rsp_valid), 32'd0);
        chk("add_alu_a_e2", 32'(alu_a),     32'd200);
        step();                                          // edge 3
        chk("add_vld_e3",   32'(rsp_valid), 32'd1);
        chk("add_res_e3",   32'(rsp_result), 32'd300);
        step();                                          // held while not ready
        chk("add_vld_hold", 32'(rsp_valid), 32'd1);
        chk("add_res_hold", 32'(rsp_result), 32'd300);
        get_rsp("add", 16'd300, 3'd1, 1'b0);
        chk("add_vld_done", 32'(rsp_valid), 32'd0);
        chk("add_starts",   32'(start_cnt), 32'd1);

        // Other opcodes
        send(8'd255, 8'd255, 3'd4);
        get_rsp("mul", 16'd65025, 3'd4, 1'b0);
        send(8'hF0, 8'h3C, 3'd2);
        get_rsp("and", 16'h0030, 3'd2, 1'b0);
        send(8'hAA, 8'hFF, 3'd3);
        get_rsp("xor", 16'h0055, 3'd3, 1'b0);

        // Illegal opcode followed by a queued NOP
        s0 = start_cnt;
        send(8'd1, 8'd2, 3'd6);
        send(8'd7, 8'd9, 3'd0);
        get_rsp("ill", 16'd0, 3'd6, 1'b1);
        chk("ill_no_start", 32'(start_cnt), 32'(s0));
        get_rsp("nop", 16'd0, 3'd0, 1'b0);
        chk("nop_start", 32'(start_cnt), 32'(s0 + 1));

        // Back-pressure: one response pending, then fill the FIFO
        send(8'd1, 8'd1, 3'd1);
        repeat (5) step();
        chk("bp_pending", 32'(rsp_valid), 32'd1);
        send(8'd10, 8'd20, 3'd1);
        send(8'd16, 8'd16, 3'd4);
        send(8'h0F, 8'hF0, 3'd3);
        send(8'hFF, 8'h81, 3'd2);
        chk("bp_level",  32'(level),     32'd4);
        chk("bp_ready",  32'(cmd_ready), 32'd0);
        cmd_a = 8'd255; cmd_b = 8'd255; cmd_op = 3'd1; cmd_valid = 1'b1;
        repeat (3) step();
        chk("bp_stall_level", 32'(level),     32'd4);
        chk("bp_stall_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        get_rsp("bp0", 16'd2, 3'd1, 1'b0);
        send(8'd255, 8'd255, 3'd1);
        get_rsp("bp1", 16'd30,    3'd1, 1'b0);
        get_rsp("bp2", 16'd256,   3'd4, 1'b0);
        get_rsp("bp3", 16'h00FF,  3'd3, 1'b0);
        get_rsp("bp4", 16'h0081,  3'd2, 1'b0);
        get_rsp("bp5", 16'd510,   3'd1, 1'b0);
        chk("bp_empty", 32'(level), 32'd0);

`ifdef TINY_ALU_ISSUER_TIMEOUT_EN
        // Timeout: WAIT entered at edge 2, expires 16 cycles later at edge 18
        alu_suppress = 1'b1;
        send(8'd5, 8'd6, 3'd1);                          // edge 0
        repeat (17) step();                              // edge 17
        chk("to_not_yet", 32'(rsp_valid), 32'd0);
        step();                                          // edge 18
        chk("to_valid", 32'(rsp_valid), 32'd1);
        get_rsp("to", 16'd0, 3'd1, 1'b1);
        alu_suppress = 1'b0;
`endif

        // Reset in the middle of WAIT drops in-flight and queued commands
        alu_suppress = 1'b1;
        send(8'd3, 8'd4, 3'd1);
        send(8'd8, 8'd8, 3'd1);
        repeat (3) step();
        chk("mid_in_wait_vld", 32'(rsp_valid), 32'd0);
        chk("mid_in_wait_lvl", 32'(level),     32'd1);
        s0 = start_cnt;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        alu_suppress = 1'b0;
        chk("mid_level",  32'(level),      32'd0);
        chk("mid_vld",    32'(rsp_valid),  32'd0);
        chk("mid_alu_a",  32'(alu_a),      32'd0);
        chk("mid_result", 32'(rsp_result), 32'd0);
        chk("mid_ready",  32'(cmd_ready),  32'd1);
        seen = 1'b0;
        repeat (10) begin
            step();
            if (rsp_valid || alu_start) seen = 1'b1;
        end
        chk("mid_quiet",  32'(seen),      32'd0);
        chk("mid_starts", 32'(start_cnt), 32'(s0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
